// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed seven-segment driver with anti-ghosting blanking, per-digit
// decimal points, leading-zero suppression and frame-aligned double buffering of display data.
module seg_scan_mux #(
    parameter int   DIGITS      = 4,
    parameter int   SCAN_DIV    = 1024,
    parameter int   BLANK_CYC   = 16,
    parameter logic CATH_ACTIVE = 1'b1
) (
    input  logic                clk_50M,
    input  logic                rst_button,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                blank_lz,
    input  logic                load,
    output logic [7:0]          digit_seg,
    output logic [DIGITS-1:0]   digit_cath,
    output logic                frame_done
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_pendVal;
    logic [DIGITS-1:0]   r_pendDp;
    logic                r_pendBlz;
    logic                r_pending;
    logic [4*DIGITS-1:0] r_shadowVal;
    logic [DIGITS-1:0]   r_shadowDp;
    logic                r_shadowBlz;

    logic                w_slotEnd;
    logic                w_frameWrap;
    logic                w_blankSlot;
    logic [3:0]          w_nibble;
    logic                w_dp;
    logic                w_suppress;
    logic                w_higherZero;
    logic [7:0]          w_segNext;
    logic [DIGITS-1:0]   w_cathNext;

    function automatic logic [7:0] encodeHex(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'b11111100;
            4'h1:    seg = 8'b01100000;
            4'h2:    seg = 8'b11011010;
            4'h3:    seg = 8'b11110010;
            4'h4:    seg = 8'b01100110;
            4'h5:    seg = 8'b10110110;
            4'h6:    seg = 8'b10111110;
            4'h7:    seg = 8'b11100000;
            4'h8:    seg = 8'b11111110;
            4'h9:    seg = 8'b11110110;
            4'hA:    seg = 8'b11101110;
            4'hB:    seg = 8'b00111110;
            4'hC:    seg = 8'b10011100;
            4'hD:    seg = 8'b01111010;
            4'hE:    seg = 8'b10011110;
            default: seg = 8'b10001110;
        endcase
        return seg;
    endfunction

    assign w_slotEnd   = (r_cnt == CNT_LAST);
    assign w_frameWrap = w_slotEnd && (r_idx == IDX_LAST);
    assign w_blankSlot = (r_cnt < CNT_BLANK);

    always_ff @(posedge clk_50M) begin
        if (rst_button) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slotEnd) begin
            r_cnt <= '0;
            r_idx <= w_frameWrap ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A load landing on the wrap cycle goes straight into the shadow so it is not a frame late.
    always_ff @(posedge clk_50M) begin
        if (rst_button) begin
            r_pendVal   <= '0;
            r_pendDp    <= '0;
            r_pendBlz   <= 1'b0;
            r_pending   <= 1'b0;
            r_shadowVal <= '0;
            r_shadowDp  <= '0;
            r_shadowBlz <= 1'b0;
        end else begin
            if (load) begin
                r_pendVal <= value;
                r_pendDp  <= dp_in;
                r_pendBlz <= blank_lz;
                r_pending <= 1'b1;
            end
            if (w_frameWrap) begin
                r_pending <= 1'b0;
                if (load) begin
                    r_shadowVal <= value;
                    r_shadowDp  <= dp_in;
                    r_shadowBlz <= blank_lz;
                end else if (r_pending) begin
                    r_shadowVal <= r_pendVal;
                    r_shadowDp  <= r_pendDp;
                    r_shadowBlz <= r_pendBlz;
                end
            end
        end
    end

    // Walk from the top digit down so w_higherZero means "this and every higher nibble is zero".
    always_comb begin
        w_nibble     = 4'h0;
        w_dp         = 1'b0;
        w_suppress   = 1'b0;
        w_higherZero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_higherZero = w_higherZero && (r_shadowVal[4*i +: 4] == 4'h0);
            if (r_idx == IDX_W'(i)) begin
                w_nibble   = r_shadowVal[4*i +: 4];
                w_dp       = r_shadowDp[i];
                w_suppress = r_shadowBlz && w_higherZero && (i != 0);
            end
        end
    end

    always_comb begin
        w_segNext  = 8'h00;
        w_cathNext = {DIGITS{~CATH_ACTIVE}};
        if (!w_blankSlot) begin
            w_segNext = (w_suppress ? 8'h00 : encodeHex(w_nibble)) | {7'b0000000, w_dp};
            for (int i = 0; i < DIGITS; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    w_cathNext[i] = CATH_ACTIVE;
                end
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst_button) begin
            digit_seg  <= 8'h00;
            digit_cath <= {DIGITS{~CATH_ACTIVE}};
            frame_done <= 1'b0;
        end else begin
            digit_seg  <= w_segNext;
            digit_cath <= w_cathNext;
            frame_done <= w_frameWrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: self-checking bench for seg_scan_mux using a cycle-count reference model,
// a table of display vectors, hand-written corner sequences and randomized traffic.
module tb_seg_scan_mux;
    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = DIGITS * SCAN_DIV;

    logic        clk_50M = 1'b0;
    logic        rst_button;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        load;
    logic [7:0]  digit_seg;
    logic [3:0]  digit_cath;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    // Reference model: position in the scan derives from a cycle count since reset.
    int          tick;
    logic [15:0] mShadowVal, mPendVal;
    logic [3:0]  mShadowDp, mPendDp;
    logic        mShadowBlz, mPendBlz, mPending;
    logic [7:0]  segTab [16];

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dp;
        logic            blz;
        logic [3:0][7:0] segs;
    } vec_t;
    vec_t vecs [8];

    always #10 clk_50M = ~clk_50M;

    seg_scan_mux #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .CATH_ACTIVE(1'b1)
    ) dut (
        .clk_50M(clk_50M), .rst_button(rst_button), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .load(load), .digit_seg(digit_seg), .digit_cath(digit_cath),
        .frame_done(frame_done)
    );

    function automatic logic [7:0] modelSeg(input int d);
        logic [15:0] upper;
        logic [7:0]  s;
        upper = mShadowVal >> (4 * d);
        if (mShadowBlz && d != 0 && upper == 16'h0000) s = 8'h00;
        else s = segTab[upper[3:0]];
        s[0] = s[0] | mShadowDp[d];
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s tick=%0d actual=%0h required=%0h", name, tick, act, req);
        end
    endtask

    // One clock: drive inputs, predict the registered outputs, check them, then advance the model.
    task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic [3:0] d,
                                 input logic b, input logic rst);
        logic [7:0] expSeg;
        logic [3:0] expCath;
        logic       expFd;
        int         c, di;
        load = ld; value = v; dp_in = d; blank_lz = b; rst_button = rst;
        expSeg = 8'h00; expCath = 4'b0000; expFd = 1'b0;
        if (!rst) begin
            c  = tick % SCAN_DIV;
            di = (tick / SCAN_DIV) % DIGITS;
            if (c >= BLANK_CYC) begin
                expCath = 4'(1 << di);
                expSeg  = modelSeg(di);
            end
            expFd = ((tick % FRAME) == FRAME - 1);
        end
        @(posedge clk_50M);
        #1;
        checkOutput("seg", 32'(digit_seg), 32'(expSeg));
        checkOutput("cath", 32'(digit_cath), 32'(expCath));
        checkOutput("frame_done", 32'(frame_done), 32'(expFd));
        if (rst) begin
            tick = 0;
            mShadowVal = '0; mShadowDp = '0; mShadowBlz = 1'b0;
            mPendVal = '0; mPendDp = '0; mPendBlz = 1'b0; mPending = 1'b0;
        end else begin
            if (ld) begin
                mPendVal = v; mPendDp = d; mPendBlz = b; mPending = 1'b1;
            end
            if ((tick % FRAME) == FRAME - 1 && mPending) begin
                mShadowVal = mPendVal; mShadowDp = mPendDp; mShadowBlz = mPendBlz;
                mPending = 1'b0;
            end
            tick++;
        end
    endtask

    task automatic idleStep();
        applyStimulus(1'b0, 16'($urandom), 4'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic runTo(input int pos);
        while ((tick % FRAME) != pos) idleStep();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog tick=%0d actual=timeout required=finish", tick);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fdSteps [$];
        segTab = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                   8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
        vecs[0] = '{16'h12AF, 4'b0000, 1'b0, {8'h60, 8'hDA, 8'hEE, 8'h8E}};
        vecs[1] = '{16'h0070, 4'b1000, 1'b1, {8'h01, 8'h00, 8'hE0, 8'hFC}};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {8'h00, 8'h00, 8'h00, 8'hFC}};
        vecs[3] = '{16'h0000, 4'b0101, 1'b0, {8'hFC, 8'hFD, 8'hFC, 8'hFD}};
        vecs[4] = '{16'h0105, 4'b0000, 1'b1, {8'h00, 8'h60, 8'hFC, 8'hB6}};
        vecs[5] = '{16'hF0E0, 4'b0010, 1'b1, {8'h8E, 8'hFC, 8'h9F, 8'hFC}};
        vecs[6] = '{16'h3C9D, 4'b1111, 1'b0, {8'hF3, 8'h9D, 8'hF7, 8'h7B}};
        vecs[7] = '{16'h0008, 4'b0001, 1'b1, {8'h00, 8'h00, 8'h00, 8'hFF}};

        rst_button = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;
        tick = 0;
        mShadowVal = '0; mShadowDp = '0; mShadowBlz = 1'b0;
        mPendVal = '0; mPendDp = '0; mPendBlz = 1'b0; mPending = 1'b0;

        // Reset, first slot timing and frame_done period.
        repeat (3) applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0, 1'b1);
        for (int k = 1; k <= 64; k++) begin
            applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
            if (k <= 2) checkOutput("post_reset_blank", 32'(digit_cath), 32'h0);
            if (k == 3) checkOutput("first_slot_cath", 32'(digit_cath), 32'h1);
            if (frame_done) fdSteps.push_back(k);
        end
        checkOutput("frame_done_count", 32'(fdSteps.size()), 32'd2);
        if (fdSteps.size() == 2) begin
            checkOutput("frame_done_first", 32'(fdSteps[0]), 32'd32);
            checkOutput("frame_done_period", 32'(fdSteps[1] - fdSteps[0]), 32'd32);
        end

        // Table-driven display vectors, each checked in the frame after its commit.
        for (int v = 0; v < 8; v++) begin
            runTo(3 + int'($urandom_range(0, 25)));
            applyStimulus(1'b1, vecs[v].val, vecs[v].dp, vecs[v].blz, 1'b0);
            runTo(0);
            for (int j = 0; j < FRAME; j++) begin
                idleStep();
                if ((j % SCAN_DIV) == 4)
                    checkOutput($sformatf("vec%0d_digit%0d", v, j / SCAN_DIV),
                                32'(digit_seg), 32'(vecs[v].segs[j / SCAN_DIV]));
            end
        end

        // Tear-free update: a second load mid-frame must not disturb the frame on screen.
        runTo(20);
        applyStimulus(1'b1, 16'h1111, 4'h0, 1'b0, 1'b0);
        runTo(10);
        applyStimulus(1'b1, 16'h2222, 4'h0, 1'b0, 1'b0);
        runTo(28);
        idleStep();
        checkOutput("tear_old_frame", 32'(digit_seg), 32'h60);
        runTo(4);
        idleStep();
        checkOutput("tear_new_frame", 32'(digit_seg), 32'hDA);

        // Load exactly on the wrap cycle is committed at that same wrap.
        runTo(31);
        applyStimulus(1'b1, 16'h00A0, 4'h0, 1'b0, 1'b0);
        runTo(12);
        idleStep();
        checkOutput("wrap_load_digit1", 32'(digit_seg), 32'hEE);

        // Reset during digit 2's active slot with a load pending.
        runTo(5);
        applyStimulus(1'b1, 16'h9876, 4'hF, 1'b1, 1'b0);
        runTo(20);
        applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0, 1'b1);
        checkOutput("midreset_seg", 32'(digit_seg), 32'h0);
        checkOutput("midreset_cath", 32'(digit_cath), 32'h0);
        repeat (3) applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
        checkOutput("midreset_restart_cath", 32'(digit_cath), 32'h1);
        checkOutput("midreset_restart_seg", 32'(digit_seg), 32'hFC);
        runTo(4);
        idleStep();
        checkOutput("midreset_pend_dropped", 32'(digit_seg), 32'hFC);

        // Randomized traffic with zero-heavy values and occasional resets.
        for (int n = 0; n < 800; n++) begin
            logic [15:0] rv;
            rv = 16'h0000;
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 1) == 1) rv[4*k +: 4] = 4'($urandom);
            applyStimulus(($urandom_range(0, 5) == 0), rv, 4'($urandom), 1'($urandom),
                          ($urandom_range(0, 249) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
